// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll tally block: die encodings,
// per-die face limits, FSM state type and the face count.
package dice_pkg;

   localparam int NUM_FACES = 20;

   localparam logic [1:0] DIE_D4  = 2'b00;
   localparam logic [1:0] DIE_D6  = 2'b01;
   localparam logic [1:0] DIE_D8  = 2'b10;
   localparam logic [1:0] DIE_D20 = 2'b11;

   localparam logic [7:0] MAX_D4  = 8'd4;
   localparam logic [7:0] MAX_D6  = 8'd6;
   localparam logic [7:0] MAX_D8  = 8'd8;
   localparam logic [7:0] MAX_D20 = 8'd20;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   // Highest legal face for a given die encoding.
   function automatic logic [7:0] face_max(input logic [1:0] die);
      logic [7:0] m;
      case (die)
         DIE_D4:  m = MAX_D4;
         DIE_D6:  m = MAX_D6;
         DIE_D8:  m = MAX_D8;
         DIE_D20: m = MAX_D20;
         default: m = MAX_D20;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dice_range_check.sv
// Combinational legality check: is a rolled value a real face of the active die?
module dice_range_check
   import dice_pkg::*;
(
   input  logic [1:0] die_active,
   input  logic [7:0] sample,
   output logic       in_range
);

   // Zero is never a face; anything above the die's max is an error.
   always_comb begin
      in_range = (sample != 8'd0) && (sample <= face_max(die_active));
   end

endmodule

// File: rtl/dice_roll_tally.sv
// Per-face histogram of dice rolls with an error tally for illegal values.
// A clear (or reset) sweeps the 20 face counters to zero, one per cycle,
// before samples are accepted again.
module dice_roll_tally
   import dice_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       die_select,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [7:0]       sample,
   output logic             sample_ready,
   input  logic             rd_en,
   input  logic [4:0]       rd_face,
   output logic             rd_valid,
   output logic [CNT_W-1:0] rd_data,
   output logic [CNT_W-1:0] total_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic [7:0]       last_bad,
   output logic [1:0]       die_active
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_FACES - 1);

   state_t           state;
   logic [4:0]       sweep;
   logic [CNT_W-1:0] count [NUM_FACES];

   logic             in_range;
   logic             accept;
   logic             restart;
   logic [4:0]       samp_idx;
   logic [4:0]       rd_idx;
   logic             rd_face_ok;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   dice_range_check u_range (
      .die_active (die_active),
      .sample     (sample),
      .in_range   (in_range)
   );

   assign sample_ready = (state == ST_COUNT);
   assign accept       = sample_valid && sample_ready;
   assign restart      = rst || clear;
   assign samp_idx     = sample[4:0] - 5'd1;
   assign rd_idx       = rd_face - 5'd1;
   assign rd_face_ok   = (rd_face != 5'd0) && (rd_face <= 5'(NUM_FACES));

   // FSM and summary registers; reset and clear both restart the sweep
   // and drop any sample offered in the same cycle.
   always_ff @(posedge clk) begin
      if (restart) begin
         state       <= ST_CLEAR;
         sweep       <= 5'd0;
         die_active  <= die_select;
         total_count <= '0;
         err_count   <= '0;
         err_flag    <= 1'b0;
         last_bad    <= 8'd0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (sweep == LAST_IDX) begin
                  state <= ST_COUNT;
               end else begin
                  sweep <= sweep + 5'd1;
               end
            end
            ST_COUNT: begin
               if (accept) begin
                  if (in_range) begin
                     total_count <= sat_inc(total_count);
                  end else begin
                     err_count <= sat_inc(err_count);
                     err_flag  <= 1'b1;
                     last_bad  <= sample;
                  end
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // Face counter array: zeroed by the sweep, bumped by accepted legal rolls.
   always_ff @(posedge clk) begin
      if (!restart) begin
         if (state == ST_CLEAR) begin
            count[sweep] <= '0;
         end else if (accept && in_range) begin
            count[samp_idx] <= sat_inc(count[samp_idx]);
         end
      end
   end

   // Read port: one-cycle latency, sees the value before any same-cycle update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_data  <= (rd_en && rd_face_ok) ? count[rd_idx] : '0;
      end
   end

endmodule

// File: doc/dice_roll_tally.md
DICE_ROLL_TALLY -- requirements
Module: dice_roll_tally

Interface
REQ-001 Parameter CNT_W, default 16, width of every counter and of rd_data.
REQ-002 Port clk  input  1  the single clock; every flop is on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port die_select  input  2  die type to tally against: 00=d4, 01=d6, 10=d8, 11=d20.
REQ-005 Port clear  input  1  one-cycle pulse that starts a clear sweep and re-latches die_select.
REQ-006 Port sample_valid  input  1  sample carries a rolled number this cycle.
REQ-007 Port sample  input  8  rolled number from the dice roller.
REQ-008 Port sample_ready  output  1  block accepts a sample this cycle.
REQ-009 Port rd_en  input  1  read request for one face counter.
REQ-010 Port rd_face  input  5  face to read, valid range 1..20.
REQ-011 Port rd_valid  output  1  rd_data is valid this cycle.
REQ-012 Port rd_data  output  CNT_W  count for the requested face.
REQ-013 Port total_count  output  CNT_W  number of accepted in-range samples.
REQ-014 Port err_count  output  CNT_W  number of accepted out-of-range samples.
REQ-015 Port err_flag  output  1  sticky; set by any out-of-range sample.
REQ-016 Port last_bad  output  8  value of the most recent out-of-range sample.
REQ-017 Port die_active  output  2  die_select value latched at the last clear.

Function
REQ-018 The FSM SHALL have exactly two states, CLEAR and COUNT; sample_ready SHALL equal (state==COUNT).
REQ-019 CLEAR SHALL zero face counters 1..20 at one counter per cycle in ascending order, then go to COUNT on the cycle after face 20 is written (20 cycles in CLEAR).
REQ-020 On entry to CLEAR, total_count, err_count, err_flag and last_bad SHALL be zeroed, and die_active SHALL be loaded from die_select.
REQ-021 A pulse on clear SHALL force CLEAR from either state; a pulse on clear during CLEAR SHALL restart the sweep at face 1 and re-latch die_select.
REQ-022 Accept condition: sample_valid && sample_ready. Accepted samples SHALL take effect on the next clock edge; samples offered while sample_ready=0 SHALL be ignored.
REQ-023 Face max = 4/6/8/20 for die_active 00/01/10/11; a sample is in range iff 1 <= sample <= max.
REQ-024 An accepted in-range sample SHALL increment count[sample] and total_count, each saturating at all-ones.
REQ-025 An accepted out-of-range sample (including 0) SHALL increment err_count (saturating), set err_flag and load last_bad; it SHALL NOT change any face counter.
REQ-026 A change on die_select outside a clear SHALL have no effect.
REQ-027 A read SHALL have 1-cycle latency: when rd_en=1 in cycle N, rd_valid=1 and rd_data = count[rd_face] in cycle N+1; otherwise rd_valid=0.
REQ-028 If rd_face is 0 or greater than 20, rd_data SHALL be 0 with rd_valid=1.
REQ-029 When a read and an increment hit the same face in the same cycle, rd_data SHALL return the pre-increment value.
REQ-030 Reads SHALL be serviced in both states; during CLEAR a read returns the stored value at that cycle.
REQ-031 Clear takes priority over a sample accepted in the same cycle; that sample SHALL be discarded.

Reset
REQ-032 rst SHALL take priority over every input, force state=CLEAR with the sweep at face 1, and set die_active=die_select.
REQ-033 While rst is asserted: sample_ready=0, rd_valid=0, rd_data=0, total_count=0, err_count=0, err_flag=0, last_bad=0.
REQ-034 Face counter contents need not be reset directly; the post-reset sweep SHALL zero them before the block enters COUNT.
REQ-035 A rst asserted mid-sweep or mid-count SHALL restart the full 20-cycle sweep.

Structure
REQ-036 Shared package dice_pkg SHALL hold: the die_select encoding constants, the face-max constants 4/6/8/20, the FSM state enum and NUM_FACES=20.
REQ-037 Sub-module dice_range_check SHALL be combinational: inputs die_active and sample, outputs in_range.
REQ-038 Face counters SHALL be a 20-entry CNT_W register array indexed by face-1.

Verification
REQ-039 Reset, then wait 20 cycles -> sample_ready rises on cycle 21; reads of faces 1..20 all return 0.
REQ-040 die_select=01, clear, feed 3,3,6,1 -> count[3]=2, count[6]=1, count[1]=1, total_count=4, err_count=0.
REQ-041 die_active=00, feed 0, 5, 2 -> err_count=2, err_flag=1, last_bad=5, count[2]=1, total_count=1.
REQ-042 CNT_W=4, feed seventeen 7s on d8 -> count[7]=15, total_count=15, no wrap to 0.
REQ-043 Same-cycle read and write of face 2 (count=3) -> rd_data=3 next cycle; a read one cycle later returns 4.
REQ-044 Pulse clear with sample_valid=1, sample=1 in the same cycle -> sample discarded; sample_ready=0 for 20 cycles; count[1]=0 afterwards.
